// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the BCD calculator operand-entry front end.
//   state_t    : entry FSM states (operand A, operand B, result shown)
//   KEY_*      : keypad codes with a non-digit meaning
//   DISP_*     : disp_mode encodings driven to the display mux
package bcd_calc_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_t;

    localparam logic [3:0] KEY_PLUS = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;
    localparam logic [3:0] KEY_BS   = 4'hD;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_SUM = 2'd2;

    // Operands hold four packed BCD digits, digit 0 in bits [3:0].
    localparam int unsigned OP_W = 16;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad synchroniser and debouncer.
//   clk, rst_n    : clock, asynchronous active-low reset
//   key_down      : raw "key held" level, asynchronous to clk
//   key_code      : raw key code, asynchronous to clk
//   accept_pulse  : combinational strobe, high for the one cycle before the
//                   edge at which a press is accepted (consumer registers it)
//   code_q        : synchronised key code, valid while accept_pulse is high
module key_debounce #(
    parameter logic [15:0] DEBOUNCE = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_down,
    input  logic [3:0] key_code,
    output logic       accept_pulse,
    output logic [3:0] code_q
);

    logic        down_s1;
    logic        down_s2;
    logic [3:0]  code_s1;
    logic        level;       // level of down_s2 seen at the previous edge
    logic [15:0] stable_cnt;  // clocks down_s2 has held its current level
    logic [15:0] cnt_nxt;
    logic        settled;
    logic        armed;

    // The count saturates at DEBOUNCE so a long hold never wraps back into
    // looking like a fresh, just-settled level.
    always_comb begin
        cnt_nxt = stable_cnt;
        if (down_s2 != level) begin
            cnt_nxt = 16'd1;
        end else if (stable_cnt != DEBOUNCE) begin
            cnt_nxt = stable_cnt + 16'd1;
        end
        settled      = (cnt_nxt == DEBOUNCE);
        accept_pulse = armed && down_s2 && settled;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_s1    <= 1'b0;
            down_s2    <= 1'b0;
            code_s1    <= 4'd0;
            code_q     <= 4'd0;
            level      <= 1'b0;
            stable_cnt <= 16'd0;
            armed      <= 1'b1;
        end else begin
            down_s1    <= key_down;
            down_s2    <= down_s1;
            code_s1    <= key_code;
            code_q     <= code_s1;
            level      <= down_s2;
            stable_cnt <= cnt_nxt;
            if (accept_pulse) begin
                armed <= 1'b0;
            end else if (!down_s2 && settled) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_key_entry.sv
// Operand-entry front end for the BCD adder.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_down     : raw keypad "key held" level (asynchronous)
//   key_code     : raw key code (asynchronous)
//   a0..a3       : operand A BCD digits, a0 least significant
//   b0..b3       : operand B BCD digits, b0 least significant
//   disp_mode    : 0 show A, 1 show B, 2 show sum
//   key_accept   : one-clock pulse per accepted key press
//   entry_err    : one-clock pulse, coincident with key_accept, on a rejected key
module bcd_key_entry
    import bcd_calc_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_down,
    input  logic [3:0] key_code,
    output logic [3:0] a0,
    output logic [3:0] a1,
    output logic [3:0] a2,
    output logic [3:0] a3,
    output logic [3:0] b0,
    output logic [3:0] b1,
    output logic [3:0] b2,
    output logic [3:0] b3,
    output logic [1:0] disp_mode,
    output logic       key_accept,
    output logic       entry_err
);

    logic            accept;
    logic [3:0]      code;
    state_t          state;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic [2:0]      cnt_a;
    logic [2:0]      cnt_b;

    key_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_down    (key_down),
        .key_code    (key_code),
        .accept_pulse(accept),
        .code_q      (code)
    );

    assign {a3, a2, a1, a0} = op_a;
    assign {b3, b2, b1, b0} = op_b;

    // With a zero count the operand is replaced rather than shifted; this makes
    // the first digit after a chain '+' start B afresh even though the old B
    // is still on display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_A;
            disp_mode  <= DISP_A;
            op_a       <= '0;
            op_b       <= '0;
            cnt_a      <= 3'd0;
            cnt_b      <= 3'd0;
            key_accept <= 1'b0;
            entry_err  <= 1'b0;
        end else begin
            key_accept <= accept;
            entry_err  <= 1'b0;
            if (accept) begin
                if (code == KEY_CLR) begin
                    op_a      <= '0;
                    op_b      <= '0;
                    cnt_a     <= 3'd0;
                    cnt_b     <= 3'd0;
                    state     <= S_A;
                    disp_mode <= DISP_A;
                end else begin
                    case (state)
                        S_A: begin
                            if (is_digit(code)) begin
                                if (cnt_a == 3'd0) begin
                                    op_a  <= {12'd0, code};
                                    cnt_a <= 3'd1;
                                end else if (cnt_a < 3'd4) begin
                                    op_a  <= {op_a[11:0], code};
                                    cnt_a <= cnt_a + 3'd1;
                                end else begin
                                    entry_err <= 1'b1;
                                end
                            end else if (code == KEY_BS) begin
                                if (cnt_a != 3'd0) begin
                                    op_a  <= {4'd0, op_a[15:4]};
                                    cnt_a <= cnt_a - 3'd1;
                                end else begin
                                    entry_err <= 1'b1;
                                end
                            end else if (code == KEY_PLUS) begin
                                op_b      <= '0;
                                cnt_b     <= 3'd0;
                                state     <= S_B;
                                disp_mode <= DISP_B;
                            end else if (code == KEY_EQ) begin
                                entry_err <= 1'b1;
                            end
                        end
                        S_B: begin
                            if (is_digit(code)) begin
                                if (cnt_b == 3'd0) begin
                                    op_b  <= {12'd0, code};
                                    cnt_b <= 3'd1;
                                end else if (cnt_b < 3'd4) begin
                                    op_b  <= {op_b[11:0], code};
                                    cnt_b <= cnt_b + 3'd1;
                                end else begin
                                    entry_err <= 1'b1;
                                end
                            end else if (code == KEY_BS) begin
                                if (cnt_b != 3'd0) begin
                                    op_b  <= {4'd0, op_b[15:4]};
                                    cnt_b <= cnt_b - 3'd1;
                                end else begin
                                    entry_err <= 1'b1;
                                end
                            end else if (code == KEY_EQ) begin
                                state     <= S_RES;
                                disp_mode <= DISP_SUM;
                            end else if (code == KEY_PLUS) begin
                                entry_err <= 1'b1;
                            end
                        end
                        S_RES: begin
                            if (is_digit(code)) begin
                                op_a      <= {12'd0, code};
                                cnt_a     <= 3'd1;
                                op_b      <= '0;
                                cnt_b     <= 3'd0;
                                state     <= S_A;
                                disp_mode <= DISP_A;
                            end else if (code == KEY_PLUS) begin
                                cnt_b     <= 3'd0;
                                state     <= S_B;
                                disp_mode <= DISP_B;
                            end else if (code == KEY_EQ || code == KEY_BS) begin
                                entry_err <= 1'b1;
                            end
                        end
                        default: begin
                            state     <= S_A;
                            disp_mode <= DISP_A;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_key_entry.sv
module tb_bcd_key_entry;

    logic       clk;
    logic       rst_n;
    logic       key_down;
    logic [3:0] key_code;
    logic [3:0] a0, a1, a2, a3;
    logic [3:0] b0, b1, b2, b3;
    logic [1:0] disp_mode;
    logic       key_accept;
    logic       entry_err;

    logic [15:0] a_val;
    logic [15:0] b_val;
    int          checks;
    int          errors;
    int          last_lat;

    assign a_val = {a3, a2, a1, a0};
    assign b_val = {b3, b2, b1, b0};

    bcd_key_entry #(
        .DEBOUNCE(16'd4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_down  (key_down),
        .key_code  (key_code),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .disp_mode (disp_mode),
        .key_accept(key_accept),
        .entry_err (entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // entry_err must only ever appear together with key_accept.
    always @(negedge clk) begin
        if (entry_err === 1'b1) check_eq("err_alone", 32'(key_accept), 32'd1);
    end

    task automatic press(input logic [3:0] code, input logic exp_err, input string tag);
        int   n;
        int   extra;
        logic err;
        @(negedge clk);
        key_down = 1'b1;
        key_code = code;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_accept && n < 40);
        err = entry_err;
        last_lat = n;
        check_eq({tag, "_acc"}, 32'(key_accept), 32'd1);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (key_accept) extra++;
        end
        check_eq({tag, "_rpt"}, 32'(extra), 32'd0);
        key_down = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic count_accepts(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (key_accept) n++;
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        last_lat = 0;
        key_down = 1'b0;
        key_code = 4'd0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_a", 32'(a_val), 32'h0);
        check_eq("rst_b", 32'(b_val), 32'h0);
        check_eq("rst_disp", 32'(disp_mode), 32'd0);
        check_eq("rst_acc", 32'(key_accept), 32'd0);
        check_eq("rst_err", 32'(entry_err), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Four digits fill A, the fifth is rejected.
        press(4'd1, 1'b0, "d1");
        check_eq("latency", 32'(last_lat), 32'd6);
        check_eq("a_1", 32'(a_val), 32'h0001);
        press(4'd2, 1'b0, "d2");
        press(4'd3, 1'b0, "d3");
        press(4'd4, 1'b0, "d4");
        check_eq("a_1234", 32'(a_val), 32'h1234);
        press(4'd5, 1'b1, "d5");
        check_eq("a_full", 32'(a_val), 32'h1234);
        press(4'hB, 1'b1, "eq_in_a");
        check_eq("disp_eq_a", 32'(disp_mode), 32'd0);

        // 7 + 89 =
        press(4'hC, 1'b0, "clr0");
        check_eq("clr0_a", 32'(a_val), 32'h0);
        press(4'd7, 1'b0, "d7");
        check_eq("a_7", 32'(a_val), 32'h0007);
        check_eq("disp_a", 32'(disp_mode), 32'd0);
        press(4'hA, 1'b0, "plus");
        check_eq("disp_b", 32'(disp_mode), 32'd1);
        check_eq("b_clr", 32'(b_val), 32'h0);
        press(4'hA, 1'b1, "plus_in_b");
        press(4'd8, 1'b0, "d8");
        press(4'd9, 1'b0, "d9");
        check_eq("b_89", 32'(b_val), 32'h0089);
        press(4'hB, 1'b0, "eq");
        check_eq("disp_sum", 32'(disp_mode), 32'd2);
        check_eq("res_a", 32'(a_val), 32'h0007);
        check_eq("res_b", 32'(b_val), 32'h0089);
        press(4'hD, 1'b1, "bs_in_res");
        check_eq("res_b_keep", 32'(b_val), 32'h0089);

        // Chain: '+' keeps A, next digit restarts B.
        press(4'hA, 1'b0, "chain");
        check_eq("chain_disp", 32'(disp_mode), 32'd1);
        check_eq("chain_b_kept", 32'(b_val), 32'h0089);
        press(4'd1, 1'b0, "chain_d1");
        check_eq("chain_b", 32'(b_val), 32'h0001);
        check_eq("chain_a", 32'(a_val), 32'h0007);
        press(4'hC, 1'b0, "clr1");
        check_eq("clr1_a", 32'(a_val), 32'h0);
        check_eq("clr1_b", 32'(b_val), 32'h0);
        check_eq("clr1_disp", 32'(disp_mode), 32'd0);

        // Backspace.
        press(4'd4, 1'b0, "bs_d4");
        press(4'd5, 1'b0, "bs_d5");
        check_eq("a_45", 32'(a_val), 32'h0045);
        press(4'hD, 1'b0, "bs1");
        check_eq("a_4", 32'(a_val), 32'h0004);
        press(4'hD, 1'b0, "bs2");
        check_eq("a_0", 32'(a_val), 32'h0000);
        press(4'hD, 1'b1, "bs3");
        check_eq("a_0_keep", 32'(a_val), 32'h0000);

        // Glitch then long hold of an ignored key.
        @(negedge clk);
        key_code = 4'hE;
        key_down = 1'b1;
        repeat (3) @(negedge clk);
        key_down = 1'b0;
        count_accepts(15, n);
        check_eq("glitch", 32'(n), 32'd0);
        key_down = 1'b1;
        count_accepts(100, n);
        check_eq("hold_once", 32'(n), 32'd1);
        key_down = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("ign_a", 32'(a_val), 32'h0);
        check_eq("ign_disp", 32'(disp_mode), 32'd0);

        // Reset in the middle of a debounce window.
        press(4'd9, 1'b0, "pre_rst");
        press(4'hA, 1'b0, "pre_rst_plus");
        check_eq("pre_rst_disp", 32'(disp_mode), 32'd1);
        @(negedge clk);
        key_code = 4'd3;
        key_down = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_a", 32'(a_val), 32'h0);
        check_eq("mid_rst_disp", 32'(disp_mode), 32'd0);
        check_eq("mid_rst_acc", 32'(key_accept), 32'd0);
        key_down = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_accepts(20, n);
        check_eq("post_rst_none", 32'(n), 32'd0);
        press(4'd6, 1'b0, "post_rst");
        check_eq("post_rst_a", 32'(a_val), 32'h0006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
